// File: rtl/mul_float_param.sv
// mul_float_param -- parametrised IEEE-754-style binary floating-point multiplier.
//
// Pipeline: operand register -> S1 unpack/multiply -> S2 normalise/round ->
// S3 special-case/pack (output register). Accepted at edge N, result valid
// after edge N+3. Valid/busy handshake; a stalled output freezes every stage.
// Subnormal inputs are read as signed zero and tiny results flush to zero.
//
// Ports:
//   iCLOCK        rising-edge clock
//   inRESET       asynchronous active-low reset
//   iRESET_SYNC   synchronous active-high clear
//   iDATA_REQ     operands valid
//   oDATA_BUSY    pipeline stalled, operands not taken
//   iDATA_A/B     operands, W = 1+EXP_W+FRACT_W bits
//   iDATA_RM      rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   oDATA_VALID   result valid
//   iDATA_BUSY    downstream cannot accept
//   oDATA         product
//   oDATA_FLAGS   {NV, OF, UF, NX}
module mul_float_param #(
  parameter int EXP_W   = 8,
  parameter int FRACT_W = 23
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iRESET_SYNC,
  input  logic                   iDATA_REQ,
  output logic                   oDATA_BUSY,
  input  logic [EXP_W+FRACT_W:0] iDATA_A,
  input  logic [EXP_W+FRACT_W:0] iDATA_B,
  input  logic [1:0]             iDATA_RM,
  output logic                   oDATA_VALID,
  input  logic                   iDATA_BUSY,
  output logic [EXP_W+FRACT_W:0] oDATA,
  output logic [3:0]             oDATA_FLAGS
);

  localparam int W  = 1 + EXP_W + FRACT_W;
  localparam int M  = FRACT_W + 1;        // significand width incl. hidden bit
  localparam int P  = 2 * M;              // full product width
  localparam int XW = EXP_W + 2;          // signed working exponent width

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;

  localparam logic signed [XW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [XW-1:0] EXP_TOP = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};

  // Class bits forwarded to S3: [3] any NaN, [2] any sNaN, [1] any inf, [0] any zero.
  logic                 stall, adv;

  logic                 v0_reg, v1_reg, v2_reg, v3_reg;
  logic [W-1:0]         a0_reg, b0_reg;
  logic [1:0]           rm0_reg, rm1_reg, rm2_reg;
  logic                 sign1_reg, sign2_reg;
  logic [P-1:0]         prod1_reg;
  logic signed [XW-1:0] exp1_reg, exp2_reg;
  logic [3:0]           cls1_reg, cls2_reg;
  logic [FRACT_W-1:0]   fract2_reg;
  logic                 nx2_reg;
  logic [W-1:0]         data3_reg;
  logic [3:0]           flags3_reg;

  logic                 sign1_next;
  logic [P-1:0]         prod1_next;
  logic signed [XW-1:0] exp1_next, exp2_next;
  logic [3:0]           cls1_next;
  logic [FRACT_W-1:0]   fract2_next;
  logic                 nx2_next;
  logic [W-1:0]         data3_next;
  logic [3:0]           flags3_next;

  assign stall       = v3_reg & iDATA_BUSY;
  assign adv         = ~stall;
  assign oDATA_BUSY  = stall;
  assign oDATA_VALID = v3_reg;
  assign oDATA       = data3_reg;
  assign oDATA_FLAGS = flags3_reg;

  // S1: unpack and multiply significands
  logic [EXP_W-1:0]   ea, eb;
  logic [FRACT_W-1:0] fa, fb;
  logic               a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;

  always_comb begin
    ea     = a0_reg[FRACT_W +: EXP_W];
    eb     = b0_reg[FRACT_W +: EXP_W];
    fa     = a0_reg[FRACT_W-1:0];
    fb     = b0_reg[FRACT_W-1:0];
    // exp==0 covers subnormals too, so they behave as zero
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) & (fa == '0);
    b_inf  = (&eb) & (fb == '0);
    a_nan  = (&ea) & (fa != '0);
    b_nan  = (&eb) & (fb != '0);
    a_snan = a_nan & ~fa[FRACT_W-1];
    b_snan = b_nan & ~fb[FRACT_W-1];
    sign1_next = a0_reg[W-1] ^ b0_reg[W-1];
    prod1_next = {{M{1'b0}}, 1'b1, fa} * {{M{1'b0}}, 1'b1, fb};
    exp1_next  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    cls1_next  = {a_nan | b_nan, a_snan | b_snan, a_inf | b_inf, a_zero | b_zero};
  end

  // S2: normalise to 1.x and round
  logic [P-1:0]         norm;
  logic signed [XW-1:0] exp_n;
  logic [M-1:0]         kept;
  logic                 guard, sticky, inc;
  logic [M:0]           rounded;

  always_comb begin
    norm   = prod1_reg[P-1] ? prod1_reg : {prod1_reg[P-2:0], 1'b0};
    exp_n  = prod1_reg[P-1] ? exp1_reg + EXP_ONE : exp1_reg;
    kept   = norm[P-1 -: M];
    guard  = norm[FRACT_W];
    sticky = |norm[FRACT_W-1:0];
    nx2_next = guard | sticky;
    case (rm1_reg)
      RM_RNE:  inc = guard & (sticky | kept[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = nx2_next & sign1_reg;
      default: inc = nx2_next & ~sign1_reg;
    endcase
    rounded = {1'b0, kept} + {{M{1'b0}}, inc};
    // carry out of the significand means 10.000..., renormalise once more
    if (rounded[M]) begin
      fract2_next = rounded[M-1:1];
      exp2_next   = exp_n + EXP_ONE;
    end else begin
      fract2_next = rounded[FRACT_W-1:0];
      exp2_next   = exp_n;
    end
  end

  // S3: special operands, range checks, pack
  logic         ovf_inf;
  logic [W-1:0] qnan, inf_res, zero_res, maxfin;

  always_comb begin
    qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRACT_W-1){1'b0}}};
    inf_res  = {sign2_reg, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
    zero_res = {sign2_reg, {(W-1){1'b0}}};
    maxfin   = {sign2_reg, {(EXP_W-1){1'b1}}, 1'b0, {FRACT_W{1'b1}}};
    // overflow saturates to inf only when rounding away from zero in the sign's direction
    ovf_inf  = (rm2_reg == RM_RNE) | ((rm2_reg == 2'b11) & ~sign2_reg) |
               ((rm2_reg == RM_RDN) & sign2_reg);
    data3_next  = {sign2_reg, exp2_reg[EXP_W-1:0], fract2_reg};
    flags3_next = {3'b000, nx2_reg};
    if (cls2_reg[3]) begin
      data3_next  = qnan;
      flags3_next = {cls2_reg[2], 3'b000};
    end else if (cls2_reg[1] & cls2_reg[0]) begin
      data3_next  = qnan;
      flags3_next = 4'b1000;
    end else if (cls2_reg[1]) begin
      data3_next  = inf_res;
      flags3_next = 4'b0000;
    end else if (cls2_reg[0]) begin
      data3_next  = zero_res;
      flags3_next = 4'b0000;
    end else if (exp2_reg >= EXP_TOP) begin
      data3_next  = ovf_inf ? inf_res : maxfin;
      flags3_next = 4'b0101;
    end else if (exp2_reg[XW-1] | (exp2_reg == '0)) begin
      data3_next  = zero_res;
      flags3_next = 4'b0011;
    end
  end

  // Stage registers; every stage freezes while the output is stalled.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      v0_reg <= 1'b0; a0_reg <= '0; b0_reg <= '0; rm0_reg <= '0;
      v1_reg <= 1'b0; sign1_reg <= 1'b0; prod1_reg <= '0; exp1_reg <= '0;
      rm1_reg <= '0; cls1_reg <= '0;
    end else if (iRESET_SYNC) begin
      v0_reg <= 1'b0; a0_reg <= '0; b0_reg <= '0; rm0_reg <= '0;
      v1_reg <= 1'b0; sign1_reg <= 1'b0; prod1_reg <= '0; exp1_reg <= '0;
      rm1_reg <= '0; cls1_reg <= '0;
    end else if (adv) begin
      v0_reg <= iDATA_REQ;
      if (iDATA_REQ) begin
        a0_reg  <= iDATA_A;
        b0_reg  <= iDATA_B;
        rm0_reg <= iDATA_RM;
      end
      v1_reg <= v0_reg;
      if (v0_reg) begin
        sign1_reg <= sign1_next;
        prod1_reg <= prod1_next;
        exp1_reg  <= exp1_next;
        rm1_reg   <= rm0_reg;
        cls1_reg  <= cls1_next;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      v2_reg <= 1'b0; sign2_reg <= 1'b0; exp2_reg <= '0; fract2_reg <= '0;
      nx2_reg <= 1'b0; rm2_reg <= '0; cls2_reg <= '0;
      v3_reg <= 1'b0; data3_reg <= '0; flags3_reg <= '0;
    end else if (iRESET_SYNC) begin
      v2_reg <= 1'b0; sign2_reg <= 1'b0; exp2_reg <= '0; fract2_reg <= '0;
      nx2_reg <= 1'b0; rm2_reg <= '0; cls2_reg <= '0;
      v3_reg <= 1'b0; data3_reg <= '0; flags3_reg <= '0;
    end else if (adv) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        sign2_reg  <= sign1_reg;
        exp2_reg   <= exp2_next;
        fract2_reg <= fract2_next;
        nx2_reg    <= nx2_next;
        rm2_reg    <= rm1_reg;
        cls2_reg   <= cls1_reg;
      end
      v3_reg <= v2_reg;
      if (v2_reg) begin
        data3_reg  <= data3_next;
        flags3_reg <= flags3_next;
      end
    end
  end

endmodule

// File: tb/tb_mul_float_param.sv
module tb_mul_float_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, srst;
  logic        s_req, s_busy_o, s_valid, s_busy_i;
  logic [31:0] s_a, s_b, s_d;
  logic [1:0]  s_rm;
  logic [3:0]  s_f;
  logic        h_req, h_busy_o, h_valid, h_busy_i;
  logic [15:0] h_a, h_b, h_d;
  logic [1:0]  h_rm;
  logic [3:0]  h_f;

  mul_float_param u_sp (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
    .iDATA_REQ(s_req), .oDATA_BUSY(s_busy_o),
    .iDATA_A(s_a), .iDATA_B(s_b), .iDATA_RM(s_rm),
    .oDATA_VALID(s_valid), .iDATA_BUSY(s_busy_i),
    .oDATA(s_d), .oDATA_FLAGS(s_f)
  );

  mul_float_param #(.EXP_W(5), .FRACT_W(10)) u_hp (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
    .iDATA_REQ(h_req), .oDATA_BUSY(h_busy_o),
    .iDATA_A(h_a), .iDATA_B(h_b), .iDATA_RM(h_rm),
    .oDATA_VALID(h_valid), .iDATA_BUSY(h_busy_i),
    .oDATA(h_d), .oDATA_FLAGS(h_f)
  );

  typedef struct {
    string       name;
    bit          half;
    logic [31:0] a, b;
    logic [1:0]  rm;
    logic [31:0] d;
    logic [3:0]  f;
  } vec_t;

  vec_t        vecs[$];
  int          n_applied = 0;
  int          n_mis = 0;
  logic [31:0] s_q[$];
  bit          cap_en = 1'b0;

  // records every handshake-completed single-precision result
  always @(posedge clk)
    if (cap_en && s_valid && !s_busy_i) s_q.push_back(s_d);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input bit half, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] rm, input logic [31:0] d, input logic [3:0] f);
    vec_t v;
    v.name = name; v.half = half; v.a = a; v.b = b; v.rm = rm; v.d = d; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    int lat;
    bit got;
    logic [31:0] d;
    logic [3:0]  f;
    @(negedge clk);
    if (v.half) begin
      h_a = v.a[15:0]; h_b = v.b[15:0]; h_rm = v.rm; h_req = 1'b1;
    end else begin
      s_a = v.a; s_b = v.b; s_rm = v.rm; s_req = 1'b1;
    end
    @(posedge clk);
    #1;
    h_req = 1'b0;
    s_req = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (v.half ? h_valid : s_valid) got = 1'b1;
    end
    d = v.half ? {16'h0000, h_d} : s_d;
    f = v.half ? h_f : s_f;
    $display("vec %-14s a=%h b=%h rm=%0d -> %h flags %b (latency %0d)", v.name, v.a, v.b, v.rm, d, f, lat);
    check({v.name, " latency"}, lat, 3);
    check({v.name, " data"}, d, v.d);
    check({v.name, " flags"}, {28'h0, f}, {28'h0, v.f});
  endtask

  // four back-to-back squares 1..4, last accepted at the edge where the first result appears
  task automatic stream4();
    logic [31:0] ops[4];
    ops[0] = 32'h3F800000; ops[1] = 32'h40000000; ops[2] = 32'h40400000; ops[3] = 32'h40800000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_a = ops[i]; s_b = ops[i]; s_rm = 2'b00; s_req = 1'b1;
    end
    @(posedge clk);
    #1;
    s_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_q[4];
    exp_q[0] = 32'h3F800000; exp_q[1] = 32'h40800000; exp_q[2] = 32'h41100000; exp_q[3] = 32'h41800000;

    rst_n = 1'b0; srst = 1'b0;
    s_req = 1'b0; s_a = '0; s_b = '0; s_rm = '0; s_busy_i = 1'b0;
    h_req = 1'b0; h_a = '0; h_b = '0; h_rm = '0; h_busy_i = 1'b0;

    add("mul3x2",     0, 32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000);
    add("rnd_rne",    0, 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001);
    add("rnd_rtz",    0, 32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0001);
    add("rnd_rup",    0, 32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800003, 4'b0001);
    add("rnd_rdn",    0, 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800002, 4'b0001);
    add("neg_rdn",    0, 32'hBF800001, 32'h3F800001, 2'b10, 32'hBF800003, 4'b0001);
    add("neg_rup",    0, 32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800002, 4'b0001);
    add("sqrt2_rne",  0, 32'h3FB504F3, 32'h3FB504F3, 2'b00, 32'h3FFFFFFF, 4'b0001);
    add("sqrt2_carry",0, 32'h3FB504F3, 32'h3FB504F3, 2'b11, 32'h40000000, 4'b0001);
    add("inf_x_zero", 0, 32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b1000);
    add("inf_x_neg1", 0, 32'h7F800000, 32'hBF800000, 2'b00, 32'hFF800000, 4'b0000);
    add("snan_x_1",   0, 32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000);
    add("qnan_x_1",   0, 32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000);
    add("inf_x_snan", 0, 32'h7F800000, 32'h7F800001, 2'b00, 32'h7FC00000, 4'b1000);
    add("qnan_x_0",   0, 32'h7FC00000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b0000);
    add("zero_neg",   0, 32'h00000000, 32'hC0000000, 2'b00, 32'h80000000, 4'b0000);
    add("daz_pos",    0, 32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, 4'b0000);
    add("daz_neg",    0, 32'h80000001, 32'h3F800000, 2'b00, 32'h80000000, 4'b0000);
    add("ovf_rne",    0, 32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 4'b0101);
    add("ovf_rtz",    0, 32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b0101);
    add("ovf_neg_rup",0, 32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF7FFFFF, 4'b0101);
    add("ovf_neg_rdn",0, 32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF800000, 4'b0101);
    add("max_normal", 0, 32'h7EFFFFFF, 32'h40000000, 2'b00, 32'h7F7FFFFF, 4'b0000);
    add("min_normal", 0, 32'h00800000, 32'h3F800000, 2'b00, 32'h00800000, 4'b0000);
    add("uf_half",    0, 32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0011);
    add("uf_deep",    0, 32'h00800000, 32'h00800000, 2'b00, 32'h00000000, 4'b0011);
    add("h_3x2",      1, 32'h4200, 32'h4000, 2'b00, 32'h4600, 4'b0000);
    add("h_ovf_rne",  1, 32'h7BFF, 32'h4000, 2'b00, 32'h7C00, 4'b0101);
    add("h_ovf_rtz",  1, 32'h7BFF, 32'h4000, 2'b01, 32'h7BFF, 4'b0101);
    add("h_1x1",      1, 32'h3C00, 32'h3C00, 2'b00, 32'h3C00, 4'b0000);
    add("h_snan",     1, 32'h7C01, 32'h3C00, 2'b00, 32'h7E00, 4'b1000);

    // reset state
    #12;
    check("rst valid", {31'h0, s_valid}, 32'h0);
    check("rst busy", {31'h0, s_busy_o}, 32'h0);
    check("rst data", s_d, 32'h0);
    check("rst flags", {28'h0, s_f}, 32'h0);
    check("rst h valid", {31'h0, h_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // backpressure: five-cycle stall once the first of four results is valid
    s_q.delete();
    cap_en = 1'b1;
    stream4();
    check("bp first valid", {31'h0, s_valid}, 32'h1);
    s_busy_i = 1'b1;
    s_a = 32'h40A00000; s_b = 32'h40A00000; s_req = 1'b1;  // must be ignored while stalled
    #1;
    check("bp busy comb", {31'h0, s_busy_o}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp busy held", {31'h0, s_busy_o}, 32'h1);
      check("bp valid held", {31'h0, s_valid}, 32'h1);
      check("bp data held", s_d, 32'h3F800000);
    end
    s_busy_i = 1'b0;
    s_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("bp stream: %0d results collected", s_q.size());
    check("bp count", s_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("bp order", (i < s_q.size()) ? s_q[i] : 32'hXXXXXXXX, exp_q[i]);
    cap_en = 1'b0;

    // asynchronous reset mid-stream
    s_q.delete();
    cap_en = 1'b1;
    stream4();
    s_busy_i = 1'b1;
    #1;
    check("ar busy before", {31'h0, s_busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("ar valid drop", {31'h0, s_valid}, 32'h0);
    check("ar busy drop", {31'h0, s_busy_o}, 32'h0);
    check("ar data clear", s_d, 32'h0);
    check("ar flags clear", {28'h0, s_f}, 32'h0);
    s_busy_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("async reset stream: %0d results after release", s_q.size());
    check("ar no stale", s_q.size(), 0);
    check("ar valid idle", {31'h0, s_valid}, 32'h0);

    // synchronous clear mid-stream
    s_q.delete();
    stream4();
    s_busy_i = 1'b1;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    s_busy_i = 1'b0;
    check("sr valid drop", {31'h0, s_valid}, 32'h0);
    check("sr data clear", s_d, 32'h0);
    check("sr busy", {31'h0, s_busy_o}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    $display("sync clear stream: %0d results after clear", s_q.size());
    check("sr no stale", s_q.size(), 0);
    cap_en = 1'b0;

    apply(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
    $finish;
  end

endmodule

// File: doc/mul_float_param.md
Name: mul_float_param

Overview:
- Parametrised successor to the fixed single-precision floating multiplier pipeline; supports any IEEE-754-style binary format via exponent/fraction widths.
- Adds per-operation rounding mode (RNE/RTZ/RDN/RUP) and IEEE exception flags.
- 3-stage valid/busy pipeline (unpack+multiply, normalise+round, special-case+pack).
- Drop-in for FPU datapaths that need half/single/double multiplies from one source.

Parameters:
- EXP_W, 8, exponent field width (≥3); bias = 2^(EXP_W-1)-1.
- FRACT_W, 23, stored fraction width (≥2); operand width W = 1+EXP_W+FRACT_W.

Ports:
- iCLOCK  in  1  clock, rising edge.
- inRESET  in  1  asynchronous, active-low reset.
- iRESET_SYNC  in  1  synchronous clear, active-high.
- iDATA_REQ  in  1  input operands valid.
- oDATA_BUSY  out  1  pipeline stalled; input not accepted.
- iDATA_A  in  W  operand A.
- iDATA_B  in  W  operand B.
- iDATA_RM  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward −inf), 11 RUP (toward +inf).
- oDATA_VALID  out  1  result valid.
- iDATA_BUSY  in  1  downstream cannot accept.
- oDATA  out  W  product.
- oDATA_FLAGS  out  4  [3] NV invalid, [2] OF overflow, [1] UF underflow, [0] NX inexact.

Behaviour:
- Reset: inRESET low, or iRESET_SYNC high at a clock edge, clears all stage valids, oDATA_VALID, oDATA and oDATA_FLAGS to 0; oDATA_BUSY = 0. In-flight operations are discarded, not completed.
- Stall: stall = oDATA_VALID & iDATA_BUSY; oDATA_BUSY = stall (combinational).
  - When stalled, every stage register holds its value, including data, RM and valid.
  - oDATA/oDATA_FLAGS stay stable while oDATA_VALID & iDATA_BUSY.
- Accept: iDATA_REQ & !oDATA_BUSY at a rising edge.
  - Latency 3: accepted at edge N, oDATA_VALID high after edge N+3 when no stall occurs.
  - Throughput 1 op/clock. Bubbles propagate as invalid stages; there is no compaction.
  - iDATA_REQ high while oDATA_BUSY is high is ignored; the producer must hold its data.
- S1 (unpack/multiply):
  - Sign = sA^sB.
  - Subnormal inputs (exp=0, fract≠0) are treated as signed zero (DAZ); no flag is raised.
  - Significands {1,fract} multiply to a 2*(FRACT_W+1)-bit product.
  - Exponent = eA+eB−bias, held signed in EXP_W+2 bits.
  - Special-class bits (zero, inf, qNaN, sNaN per operand) are forwarded to S3.
- S2 (normalise/round):
  - If product MSB = 1, shift right 1 and increment exponent.
  - Keep FRACT_W+1 bits; guard = next bit; sticky = OR of remaining bits; NX = guard|sticky.
  - RNE: increment if guard & (sticky | lsb).
  - RTZ: never increment.
  - RDN: increment if inexact & sign.
  - RUP: increment if inexact & !sign.
  - Rounding carry-out shifts right 1 and increments the exponent again.
- S3 (exceptions/pack), in priority order:
  1. Any NaN operand → canonical qNaN (sign 0, exp all-ones, fract MSB 1, rest 0). NV set only if an operand is sNaN (fract MSB 0).
  2. Inf × zero → canonical qNaN, NV.
  3. Inf × finite/inf → signed inf, flags 0.
  4. Zero × finite → signed zero, flags 0.
  5. Exponent ≥ 2^EXP_W−1 → overflow, OF|NX.
     - Result is signed inf for RNE, RUP with positive sign, RDN with negative sign.
     - Otherwise result is signed max finite (exp all-ones−1, fract all-ones).
  6. Exponent ≤ 0 → flush to signed zero, UF|NX (no subnormal output).
  7. Otherwise normal result; flags = {0,0,0,NX}.

Test Plan:
- Single default, RNE: A=0x40400000 (3.0), B=0x40000000 (2.0) → oDATA=0x40C00000, flags 0, oDATA_VALID exactly 3 edges after accept.
- Rounding: A=B=0x3F800001. RNE → 0x3F800002 NX; RTZ → 0x3F800002 NX; RUP → 0x3F800003 NX; RDN → 0x3F800002 NX.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, NV.
  - 0x7F800000×0xBF800000 → 0xFF800000, flags 0.
  - 0x7F800001×0x3F800000 → 0x7FC00000, NV.
  - 0x7FC00000×0x3F800000 → 0x7FC00000, flags 0.
- Overflow/underflow:
  - 0x7F7FFFFF×0x40000000: RNE → 0x7F800000 OF|NX; RTZ → 0x7F7FFFFF OF|NX.
  - 0x00800000×0x3F000000 → 0x00000000 UF|NX.
- Backpressure: stream 4 back-to-back ops (1×1, 2×2, 3×3, 4×4 single) and hold iDATA_BUSY high 5 cycles once the first result is valid.
  - Required: oDATA_BUSY high throughout the stall.
  - Required: results emerge in order 0x3F800000, 0x40800000, 0x41100000, 0x41800000, none lost or duplicated.
  - Repeat with inRESET pulsed mid-stream: all valids drop immediately and no stale result appears after release.
- Half precision (EXP_W=5, FRACT_W=10): 0x4200×0x4000 → 0x4600; 0x7BFF×0x4000 RNE → 0x7C00 OF|NX.
